credit_switch_scheduler: RTL and testbench
==========================================

CREDIT_SWITCH_SCHEDULER -- requirements
Module: credit_switch_scheduler

Interface
REQ-001 Parameter N, default 5, meaning number of switch inputs [local, north, east, south, west].
REQ-002 Parameter M, default 5, meaning number of switch outputs [local, north, east, south, west].
REQ-003 Parameter MAX_CREDITS, default 4, meaning the downstream input queue depth in packets; CW = $clog2(MAX_CREDITS+1).
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 ce  in  1  clock enable; gates scheduling.
REQ-008 i_output_req  in  N x M  per-input requested-output word from the route calculators.
REQ-009 i_credit_return  in  M  per-output pulse; downstream freed one queue slot.
REQ-010 o_output_grant  out  M x N  per-output one-hot (or zero) input select, driven to the switch.
REQ-011 o_input_grant  out  N  per-input dequeue enable, driven to the input FIFOs.
REQ-012 o_data_val  out  M  per-output valid; OR of o_output_grant[m].
REQ-013 o_credit_count  out  M x CW  current credit counter per output.
REQ-014 o_credit_overflow  out  1  sticky error flag.

Function
REQ-015 Output m SHALL be eligible only when ce=1, reset=0 and credit[m] > 0.
REQ-016 An input with more than one request bit set SHALL have only its lowest-index requested output honoured.
REQ-017 Each eligible output SHALL grant exactly one requesting input, chosen round-robin starting at ptr[m] and searching upward with wrap from N-1 to 0.
REQ-018 Grants SHALL be combinational: zero-cycle latency from i_output_req to o_output_grant, o_input_grant and o_data_val.
REQ-019 o_input_grant[n] SHALL equal the OR over m of o_output_grant[m][n]; at most one bit per input SHALL be set.
REQ-020 On a clock edge where output m grants input w, ptr[m] SHALL become (w+1) mod N; with no grant, ptr[m] SHALL hold.
REQ-021 credit[m] SHALL update each edge as credit[m] - grant_m + return_m.
REQ-022 A simultaneous grant and return on output m SHALL leave credit[m] unchanged.
REQ-023 A return when credit[m] = MAX_CREDITS without a same-cycle grant SHALL saturate credit[m] at MAX_CREDITS and set o_credit_overflow.
REQ-024 Credit returns SHALL be counted regardless of ce.
REQ-025 With ce=0, all grants SHALL be zero, and pointers and the grant-driven credit decrement SHALL hold.
REQ-026 With no requests, all grant outputs SHALL be zero and pointers SHALL hold.

Reset
REQ-027 Reset SHALL set every credit[m] to MAX_CREDITS, every ptr[m] to 0, and o_credit_overflow to 0.
REQ-028 While reset=1, o_output_grant, o_input_grant and o_data_val SHALL be all zero.
REQ-029 Reset asserted mid-operation SHALL discard in-flight state and apply REQ-027 on the next edge; credit returns in that cycle SHALL be ignored.

Configuration
REQ-030 Macro CREDIT_SCHED_FIXED_PRIORITY_EN, when defined, SHALL replace round-robin with fixed priority (lowest input index wins) and SHALL remove the ptr registers.
REQ-031 When CREDIT_SCHED_FIXED_PRIORITY_EN is undefined, round-robin per REQ-017 and REQ-020 SHALL apply; all other behaviour SHALL be identical in both builds.

Verification (N=M=5, MAX_CREDITS=4)
REQ-032 After reset, inputs 0-4 all request output 2 continuously with no returns -> grants go to inputs 0,1,2,3 on four consecutive cycles, then none; credit[2]=0 and ptr[2]=4.
REQ-033 From the REQ-032 end state, a return on output 2 while input 4 requests -> no grant that cycle; the next cycle grants input 4 and credit[2] returns to 0.
REQ-034 With credit[1]=3, a grant and a return on output 1 in the same cycle -> credit[1] stays 3.
REQ-035 With credit[3]=4, a return on output 3 -> credit[3] stays 4 and o_credit_overflow=1 until reset.
REQ-036 With ce=0, requests on all outputs plus a return on output 0 at credit 3 -> all grants zero, pointers unchanged, credit[0]=4.
REQ-037 With the fixed-priority macro defined, the REQ-032 stimulus -> input 0 is granted four times, then no grant.

Source files
------------

// File: rtl/credit_switch_scheduler.sv
// Credit-based output scheduler for an NxM switch: per-output round-robin grant plus credit tracking.
// Define CREDIT_SCHED_FIXED_PRIORITY_EN to use lowest-index-wins arbitration without pointer registers.
module credit_switch_scheduler #(
    parameter int unsigned N           = 5,
    parameter int unsigned M           = 5,
    parameter int unsigned MAX_CREDITS = 4,
    localparam int unsigned CW         = $clog2(MAX_CREDITS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic [N*M-1:0]    i_output_req,
    input  logic [M-1:0]      i_credit_return,
    output logic [M*N-1:0]    o_output_grant,
    output logic [N-1:0]      o_input_grant,
    output logic [M-1:0]      o_data_val,
    output logic [M*CW-1:0]   o_credit_count,
    output logic              o_credit_overflow
);

    localparam logic [CW-1:0] MaxCredit = CW'(MAX_CREDITS);

    logic [N-1:0][M-1:0] eff_req;
    logic [M-1:0][N-1:0] grant;
    logic [M-1:0]        eligible;
    logic [M-1:0]        data_val;
    logic [M-1:0][CW-1:0] credit_q, credit_d;
    logic                overflow_q, overflow_d;

`ifndef CREDIT_SCHED_FIXED_PRIORITY_EN
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
    logic [M-1:0][PW-1:0] ptr_q, ptr_d;
`endif

    // A multi-request input only competes for its lowest-index output, so no input is double-granted.
    always_comb begin
        eff_req = '0;
        for (int unsigned n = 0; n < N; n++) begin
            logic found;
            found = 1'b0;
            for (int unsigned m = 0; m < M; m++) begin
                if (i_output_req[n*M+m] && !found) begin
                    eff_req[n][m] = 1'b1;
                    found         = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int unsigned m = 0; m < M; m++) begin
            eligible[m] = ce && !reset && (credit_q[m] != '0);
        end
    end

    always_comb begin
        grant = '0;
`ifndef CREDIT_SCHED_FIXED_PRIORITY_EN
        ptr_d = ptr_q;
`endif
        for (int unsigned m = 0; m < M; m++) begin
            logic        found;
            int unsigned idx;
            found = 1'b0;
            idx   = 0;
            if (eligible[m]) begin
                for (int unsigned k = 0; k < N; k++) begin
`ifdef CREDIT_SCHED_FIXED_PRIORITY_EN
                    idx = k;
`else
                    idx = int'(ptr_q[m]) + k;
                    if (idx >= N) idx = idx - N;
`endif
                    if (!found && eff_req[idx][m]) begin
                        grant[m][idx] = 1'b1;
                        found         = 1'b1;
`ifndef CREDIT_SCHED_FIXED_PRIORITY_EN
                        ptr_d[m] = (idx + 1 == N) ? '0 : PW'(idx + 1);
`endif
                    end
                end
            end
        end
    end

    always_comb begin
        o_input_grant = '0;
        for (int unsigned m = 0; m < M; m++) begin
            data_val[m]   = |grant[m];
            o_input_grant = o_input_grant | grant[m];
        end
    end

    // Returns are counted even with ce low; a return at full credit saturates and flags overflow.
    always_comb begin
        credit_d   = credit_q;
        overflow_d = overflow_q;
        for (int unsigned m = 0; m < M; m++) begin
            case ({data_val[m], i_credit_return[m]})
                2'b10: credit_d[m] = credit_q[m] - CW'(1);
                2'b01: begin
                    if (credit_q[m] == MaxCredit) overflow_d = 1'b1;
                    else credit_d[m] = credit_q[m] + CW'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            credit_q   <= {M{MaxCredit}};
            overflow_q <= 1'b0;
`ifndef CREDIT_SCHED_FIXED_PRIORITY_EN
            ptr_q      <= '0;
`endif
        end else begin
            credit_q   <= credit_d;
            overflow_q <= overflow_d;
`ifndef CREDIT_SCHED_FIXED_PRIORITY_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    assign o_output_grant    = grant;
    assign o_data_val        = data_val;
    assign o_credit_count    = credit_q;
    assign o_credit_overflow = overflow_q;

endmodule

// File: tb/tb_credit_switch_scheduler.sv
// Directed self-checking bench for credit_switch_scheduler (N=M=5, MAX_CREDITS=4).
module tb_credit_switch_scheduler;

    localparam int N  = 5;
    localparam int M  = 5;
    localparam int CW = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            ce;
    logic [N*M-1:0]  req;
    logic [M-1:0]    ret;
    logic [M*N-1:0]  og;
    logic [N-1:0]    ig;
    logic [M-1:0]    dv;
    logic [M*CW-1:0] cc;
    logic            ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    credit_switch_scheduler #(.N(N), .M(M), .MAX_CREDITS(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .ce               (ce),
        .i_output_req     (req),
        .i_credit_return  (ret),
        .o_output_grant   (og),
        .o_input_grant    (ig),
        .o_data_val       (dv),
        .o_credit_count   (cc),
        .o_credit_overflow(ovf)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CW-1:0] credit(input int m);
        return cc[m*CW +: CW];
    endfunction

    task automatic test_reset;
        reset = 1'b1; ce = 1'b1; req = '1; ret = '1;
        #1;
        checks++;
        if (og !== '0 || ig !== '0 || dv !== '0) begin
            errors++; $display("FAIL reset_grants: got og=%h ig=%b dv=%b want all zero", og, ig, dv);
        end
        tick;
        checks++;
        if (cc !== {M{3'd4}}) begin
            errors++; $display("FAIL reset_credits: got %h want %h", cc, {M{3'd4}});
        end
        checks++;
        if (ovf !== 1'b0) begin
            errors++; $display("FAIL reset_overflow: got %b want 0", ovf);
        end
        reset = 1'b0; req = '0; ret = '0;
    endtask

    task automatic test_rr_drain;
        logic [M*N-1:0] exp_og;
        int             exp_in;
        for (int n = 0; n < N; n++) req[n*M+2] = 1'b1;
        for (int c = 0; c < 4; c++) begin
`ifdef CREDIT_SCHED_FIXED_PRIORITY_EN
            exp_in = 0;
`else
            exp_in = c;
`endif
            exp_og = '0;
            exp_og[2*N+exp_in] = 1'b1;
            #1;
            checks++;
            if (og !== exp_og || ig !== exp_og[2*N +: N] || dv !== 5'b00100) begin
                errors++;
                $display("FAIL drain_grant c=%0d: got og=%h ig=%b dv=%b want og=%h dv=00100",
                         c, og, ig, dv, exp_og);
            end
            tick;
        end
        #1;
        checks++;
        if (og !== '0 || dv !== '0) begin
            errors++; $display("FAIL drain_exhausted: got og=%h dv=%b want zero", og, dv);
        end
        checks++;
        if (credit(2) !== 3'd0) begin
            errors++; $display("FAIL drain_credit2: got %0d want 0", credit(2));
        end
    endtask

    task automatic test_return_refill;
        logic [M*N-1:0] exp_og;
        req = '0;
        req[0*M+2] = 1'b1;
        req[4*M+2] = 1'b1;
        ret[2] = 1'b1;
        #1;
        checks++;
        if (og !== '0) begin
            errors++; $display("FAIL refill_no_grant: got og=%h want zero", og);
        end
        tick;
        ret = '0;
        checks++;
        if (credit(2) !== 3'd1) begin
            errors++; $display("FAIL refill_credit_up: got %0d want 1", credit(2));
        end
        exp_og = '0;
`ifdef CREDIT_SCHED_FIXED_PRIORITY_EN
        exp_og[2*N+0] = 1'b1;
`else
        exp_og[2*N+4] = 1'b1; // pointer left at 4 by the drain
`endif
        checks++;
        if (og !== exp_og) begin
            errors++; $display("FAIL refill_grant: got og=%h want %h", og, exp_og);
        end
        tick;
        req = '0;
        checks++;
        if (credit(2) !== 3'd0) begin
            errors++; $display("FAIL refill_credit_down: got %0d want 0", credit(2));
        end
    endtask

    task automatic test_simultaneous;
        req = '0;
        req[3*M+1] = 1'b1;
        tick;
        checks++;
        if (credit(1) !== 3'd3) begin
            errors++; $display("FAIL simul_setup: got %0d want 3", credit(1));
        end
        ret[1] = 1'b1;
        #1;
        checks++;
        if (dv !== 5'b00010 || ig !== 5'b01000) begin
            errors++; $display("FAIL simul_grant: got dv=%b ig=%b want 00010 01000", dv, ig);
        end
        tick;
        req = '0; ret = '0;
        checks++;
        if (credit(1) !== 3'd3) begin
            errors++; $display("FAIL simul_credit: got %0d want 3", credit(1));
        end
    endtask

    task automatic test_overflow;
        ret[3] = 1'b1;
        tick;
        ret = '0;
        checks++;
        if (credit(3) !== 3'd4 || ovf !== 1'b1) begin
            errors++; $display("FAIL overflow_set: got credit=%0d ovf=%b want 4 1", credit(3), ovf);
        end
        tick;
        checks++;
        if (ovf !== 1'b1) begin
            errors++; $display("FAIL overflow_sticky: got %b want 1", ovf);
        end
    endtask

    task automatic test_ce_gate;
        logic [M*N-1:0] exp_og;
        req = '0;
        req[1*M+0] = 1'b1;
        tick;
        checks++;
        if (credit(0) !== 3'd3) begin
            errors++; $display("FAIL ce_setup: got %0d want 3", credit(0));
        end
        ce = 1'b0;
        req = '0;
        for (int n = 0; n < N; n++) req[n*M+n] = 1'b1;
        ret[0] = 1'b1;
        #1;
        checks++;
        if (og !== '0 || ig !== '0 || dv !== '0) begin
            errors++; $display("FAIL ce_grants: got og=%h ig=%b dv=%b want zero", og, ig, dv);
        end
        tick;
        ret = '0;
        checks++;
        if (credit(0) !== 3'd4 || credit(1) !== 3'd3) begin
            errors++;
            $display("FAIL ce_credit: got c0=%0d c1=%0d want 4 3", credit(0), credit(1));
        end
        ce = 1'b1;
        req = '0;
        req[0*M+0] = 1'b1;
        req[2*M+0] = 1'b1;
        req[3*M+0] = 1'b1;
        exp_og = '0;
`ifdef CREDIT_SCHED_FIXED_PRIORITY_EN
        exp_og[0*N+0] = 1'b1;
`else
        exp_og[0*N+2] = 1'b1; // pointer still at 2 from the grant to input 1
`endif
        #1;
        checks++;
        if (og !== exp_og) begin
            errors++; $display("FAIL ce_ptr_hold: got og=%h want %h", og, exp_og);
        end
        tick;
        req = '0;
    endtask

    task automatic test_lowest_req;
        req = '0;
        req[2*M+1] = 1'b1;
        req[2*M+3] = 1'b1;
        req[2*M+4] = 1'b1;
        #1;
        checks++;
        if (dv !== 5'b00010 || ig !== 5'b00100 || og[1*N +: N] !== 5'b00100) begin
            errors++;
            $display("FAIL lowest_req: got og=%h ig=%b dv=%b want dv=00010 ig=00100", og, ig, dv);
        end
        tick;
        req = '0;
        checks++;
        if (credit(1) !== 3'd2 || credit(3) !== 3'd4 || credit(4) !== 3'd4) begin
            errors++;
            $display("FAIL lowest_credit: got c1=%0d c3=%0d c4=%0d want 2 4 4",
                     credit(1), credit(3), credit(4));
        end
    endtask

    task automatic test_reset_mid;
        req = '1; ret = '1; reset = 1'b1;
        #1;
        checks++;
        if (og !== '0 || ig !== '0 || dv !== '0) begin
            errors++; $display("FAIL midreset_grants: got og=%h ig=%b dv=%b want zero", og, ig, dv);
        end
        tick;
        checks++;
        if (cc !== {M{3'd4}} || ovf !== 1'b0) begin
            errors++; $display("FAIL midreset_state: got cc=%h ovf=%b want %h 0", cc, ovf, {M{3'd4}});
        end
        reset = 1'b0; req = '0; ret = '0;
        tick;
    endtask

    initial begin
        test_reset;
        test_rr_drain;
        test_return_refill;
        test_simultaneous;
        test_overflow;
        test_ce_gate;
        test_lowest_req;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
